// File: rtl/einstein_kbd_pkg.sv
// Shared types and scancode constants for the Einstein keyboard responder.
// Imported by the keymap table and the top-level matrix/FSM logic.
package einstein_kbd_pkg;

    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59;
    localparam logic [7:0] SC_CTRL   = 8'h14;
    localparam logic [7:0] SC_ALT    = 8'h11;

    typedef enum logic [1:0] {
        IDLE,
        HELD,
        RETRIG
    } kbd_state_t;

    typedef struct packed {
        logic       hit;
        logic [2:0] row;
        logic [2:0] col;
    } keymap_t;

    function automatic keymap_t km(input int r, input int c);
        keymap_t e;
        e.hit = 1'b1;
        e.row = 3'(r);
        e.col = 3'(c);
        return e;
    endfunction

endpackage

// File: rtl/einstein_keymap.sv
// PS/2 set-2 scancode to Einstein 8x8 matrix position.
// Modifiers are not listed here; the top decodes them separately.
import einstein_kbd_pkg::*;

module einstein_keymap (
    input  logic       ext,
    input  logic [7:0] code,
    output keymap_t    entry
);

    always_comb begin
        entry = '0;
        if (!ext) begin
            case (code)
                8'h16: entry = km(0, 0);
                8'h1E: entry = km(0, 1);
                8'h26: entry = km(0, 2);
                8'h25: entry = km(0, 3);
                8'h2E: entry = km(0, 4);
                8'h36: entry = km(0, 5);
                8'h3D: entry = km(0, 6);
                8'h5A: entry = km(0, 7);
                8'h1C: entry = km(1, 0);
                8'h1B: entry = km(1, 1);
                8'h23: entry = km(1, 2);
                8'h2B: entry = km(1, 3);
                8'h34: entry = km(1, 4);
                8'h33: entry = km(1, 5);
                8'h3B: entry = km(1, 6);
                8'h42: entry = km(1, 7);
                8'h15: entry = km(2, 0);
                8'h1D: entry = km(2, 1);
                8'h24: entry = km(2, 2);
                8'h2D: entry = km(2, 3);
                8'h2C: entry = km(2, 4);
                8'h35: entry = km(2, 5);
                8'h3C: entry = km(2, 6);
                8'h43: entry = km(2, 7);
                8'h44: entry = km(3, 0);
                8'h4D: entry = km(3, 1);
                8'h4B: entry = km(3, 2);
                8'h4C: entry = km(3, 3);
                8'h52: entry = km(3, 4);
                8'h54: entry = km(3, 5);
                8'h5B: entry = km(3, 6);
                8'h5D: entry = km(3, 7);
                8'h3E: entry = km(4, 0);
                8'h46: entry = km(4, 1);
                8'h45: entry = km(4, 2);
                8'h4E: entry = km(4, 3);
                8'h55: entry = km(4, 4);
                8'h66: entry = km(4, 5);
                8'h0D: entry = km(4, 6);
                8'h76: entry = km(4, 7);
                8'h1A: entry = km(5, 0);
                8'h22: entry = km(5, 1);
                8'h21: entry = km(5, 2);
                8'h2A: entry = km(5, 3);
                8'h31: entry = km(5, 4);
                8'h3A: entry = km(5, 5);
                8'h41: entry = km(5, 6);
                8'h49: entry = km(5, 7);
                8'h4A: entry = km(6, 0);
                8'h61: entry = km(6, 1);
                8'h32: entry = km(6, 2);
                8'h29: entry = km(6, 3);
                8'h58: entry = km(6, 4);
                8'h0E: entry = km(6, 5);
                8'h05: entry = km(6, 6);
                8'h06: entry = km(6, 7);
                8'h04: entry = km(7, 0);
                8'h0C: entry = km(7, 1);
                default: entry = '0;
            endcase
        end else begin
            case (code)
                8'h6B: entry = km(7, 2);
                8'h74: entry = km(7, 3);
                8'h72: entry = km(7, 4);
                8'h75: entry = km(7, 5);
                8'h6C: entry = km(7, 6);
                8'h71: entry = km(7, 7);
                default: entry = '0;
            endcase
        end
    end

endmodule

// File: rtl/einstein_keyboard.sv
// Einstein keyboard responder: ps2_key events to the PSG-scanned 8x8
// matrix, modifier lines and the kb_down interrupt line.
import einstein_kbd_pkg::*;

module einstein_keyboard #(
    parameter int RETRIG_LOW = 64,
    parameter bit COL_REG    = 1'b1
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic [10:0] ps2_key,
    input  logic        clear,
    input  logic [7:0]  kb_row,
    output logic [7:0]  kb_col,
    output logic        kb_shift,
    output logic        kb_ctrl,
    output logic        kb_graph,
    output logic        kb_down
);

    localparam int CW = $clog2(RETRIG_LOW + 1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(RETRIG_LOW - 1);

    logic       armed;
    logic       tog_q;
    logic       ev_q;
    logic [9:0] key_q;

    // armed suppresses the phantom event a stale strobe would cause after reset
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            armed <= 1'b0;
            tog_q <= 1'b0;
            ev_q  <= 1'b0;
            key_q <= '0;
        end else begin
            armed <= 1'b1;
            tog_q <= ps2_key[10];
            ev_q  <= armed & (ps2_key[10] ^ tog_q) & ~clear;
            key_q <= ps2_key[9:0];
        end
    end

    logic       ev_make;
    logic       ev_ext;
    logic [7:0] ev_code;

    assign ev_make = key_q[9];
    assign ev_ext  = key_q[8];
    assign ev_code = key_q[7:0];

    keymap_t ent;

    einstein_keymap u_keymap (
        .ext   (ev_ext),
        .code  (ev_code),
        .entry (ent)
    );

    // {ralt, lalt, rctl, lctl, rshift, lshift}
    logic [5:0] mod_q;
    logic [5:0] mod_nxt;
    logic [5:0] mod_sel;
    logic       is_mod;

    always_comb begin
        mod_sel[0] = !ev_ext && ev_code == SC_LSHIFT;
        mod_sel[1] = !ev_ext && ev_code == SC_RSHIFT;
        mod_sel[2] = !ev_ext && ev_code == SC_CTRL;
        mod_sel[3] =  ev_ext && ev_code == SC_CTRL;
        mod_sel[4] = !ev_ext && ev_code == SC_ALT;
        mod_sel[5] =  ev_ext && ev_code == SC_ALT;
        is_mod     = |mod_sel;
    end

    always_comb begin
        mod_nxt = mod_q;
        if (ev_q) begin
            if (ev_make) mod_nxt = mod_q | mod_sel;
            else         mod_nxt = mod_q & ~mod_sel;
        end
        if (clear) mod_nxt = '0;
    end

    logic [7:0][7:0] matrix_q;
    logic [7:0][7:0] matrix_nxt;
    logic            new_press;
    logic            any;

    always_comb begin
        matrix_nxt = matrix_q;
        new_press  = 1'b0;
        if (ev_q && ent.hit && !is_mod) begin
            if (ev_make) begin
                new_press = !matrix_q[ent.row][ent.col];
                matrix_nxt[ent.row][ent.col] = 1'b1;
            end else begin
                matrix_nxt[ent.row][ent.col] = 1'b0;
            end
        end
        if (clear) begin
            matrix_nxt = '0;
            new_press  = 1'b0;
        end
        any = |matrix_nxt;
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            matrix_q <= '0;
            mod_q    <= '0;
        end else begin
            matrix_q <= matrix_nxt;
            mod_q    <= mod_nxt;
        end
    end

    kbd_state_t    state_q;
    kbd_state_t    state_nxt;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_nxt;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_nxt;
            cnt_q   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state_q;
        cnt_nxt   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (new_press) state_nxt = HELD;
            end
            HELD: begin
                if (!any) begin
                    state_nxt = IDLE;
                end else if (new_press) begin
                    state_nxt = RETRIG;
                    cnt_nxt   = CNT_LOAD;
                end
            end
            RETRIG: begin
                if (new_press) begin
                    cnt_nxt = CNT_LOAD;
                end else if (cnt_q == '0) begin
                    state_nxt = any ? HELD : IDLE;
                end else begin
                    cnt_nxt = cnt_q - 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (clear) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
        end
    end

    always_comb begin
        kb_down  = (state_q == HELD);
        kb_shift = ~(mod_q[0] | mod_q[1]);
        kb_ctrl  = ~(mod_q[2] | mod_q[3]);
        kb_graph = ~(mod_q[4] | mod_q[5]);
    end

    logic [7:0] col_hit;
    logic [7:0] col_comb;

    always_comb begin
        col_hit = '0;
        for (int r = 0; r < 8; r++) begin
            col_hit = col_hit | (matrix_q[r] & {8{~kb_row[r]}});
        end
        col_comb = ~col_hit;
    end

    generate
        if (COL_REG) begin : g_col_reg
            logic [7:0] col_q;
            always_ff @(posedge clk_sys or negedge reset_n) begin
                if (!reset_n) col_q <= 8'hFF;
                else          col_q <= col_comb;
            end
            assign kb_col = col_q;
        end else begin : g_col_comb
            assign kb_col = col_comb;
        end
    endgenerate

endmodule

// File: tb/tb_einstein_keyboard.sv
// Directed bench for einstein_keyboard: matrix scan, modifiers,
// kb_down retrigger timing, clear and asynchronous reset.
module tb_einstein_keyboard;

    logic        clk_sys;
    logic        reset_n;
    logic [10:0] ps2_key;
    logic        clear;
    logic [7:0]  kb_row;
    logic [7:0]  kb_col;
    logic        kb_shift;
    logic        kb_ctrl;
    logic        kb_graph;
    logic        kb_down;

    int n_cmp = 0;
    int n_bad = 0;
    int low_cnt;
    int drops;
    int highs;

    einstein_keyboard #(
        .RETRIG_LOW (64),
        .COL_REG    (1'b1)
    ) dut (
        .clk_sys  (clk_sys),
        .reset_n  (reset_n),
        .ps2_key  (ps2_key),
        .clear    (clear),
        .kb_row   (kb_row),
        .kb_col   (kb_col),
        .kb_shift (kb_shift),
        .kb_ctrl  (kb_ctrl),
        .kb_graph (kb_graph),
        .kb_down  (kb_down)
    );

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_sys);
            #1;
        end
    endtask

    task automatic send(input logic mk, input logic ext, input logic [7:0] code);
        ps2_key = {~ps2_key[10], mk, ext, code};
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        reset_n = 1'b0;
        clear   = 1'b0;
        ps2_key = '0;
        kb_row  = 8'hFF;
        tick(2);
        chk("rst_col", kb_col, 8'hFF);
        chk("rst_down", kb_down, 1'b0);
        chk("rst_shift", kb_shift, 1'b1);
        chk("rst_ctrl", kb_ctrl, 1'b1);
        chk("rst_graph", kb_graph, 1'b1);
        reset_n = 1'b1;
        tick(2);

        kb_row = 8'hFD;
        tick(1);
        chk("t1_col", kb_col, 8'hFF);
        chk("t1_down", kb_down, 1'b0);

        send(1'b1, 1'b0, 8'h1C);
        tick(1);
        chk("t2_down_e1", kb_down, 1'b0);
        tick(1);
        chk("t2_down_e2", kb_down, 1'b1);
        tick(1);
        chk("t2_col_a", kb_col, 8'hFE);
        kb_row = 8'hFF;
        tick(1);
        chk("t2_col_ff", kb_col, 8'hFF);
        kb_row = 8'hFD;
        send(1'b0, 1'b0, 8'h1C);
        tick(3);
        chk("t2_brk_col", kb_col, 8'hFF);
        chk("t2_brk_down", kb_down, 1'b0);

        send(1'b1, 1'b0, 8'h1C);
        tick(2);
        chk("t3_held", kb_down, 1'b1);
        send(1'b1, 1'b0, 8'h32);
        tick(1);
        chk("t3_pre", kb_down, 1'b1);
        tick(1);
        chk("t3_drop", kb_down, 1'b0);
        low_cnt = 1;
        for (int i = 0; i < 150; i++) begin
            tick(1);
            if (kb_down) break;
            low_cnt++;
        end
        chk("t3_low_len", 8'(low_cnt), 8'd64);
        chk("t3_rehigh", kb_down, 1'b1);
        send(1'b1, 1'b0, 8'h1C);
        drops = 0;
        for (int i = 0; i < 6; i++) begin
            tick(1);
            if (!kb_down) drops++;
        end
        chk("t3_typematic", 8'(drops), 8'd0);
        send(1'b0, 1'b0, 8'h32);
        tick(2);
        chk("t3_brk_b", kb_down, 1'b1);
        send(1'b0, 1'b0, 8'h1C);
        tick(3);
        chk("t3_brk_all", kb_down, 1'b0);

        send(1'b1, 1'b0, 8'h12);
        tick(2);
        chk("t4_shift", kb_shift, 1'b0);
        send(1'b1, 1'b1, 8'h14);
        tick(2);
        chk("t4_ctrl", kb_ctrl, 1'b0);
        send(1'b1, 1'b0, 8'h11);
        tick(2);
        chk("t4_graph", kb_graph, 1'b0);
        tick(1);
        chk("t4_down", kb_down, 1'b0);
        chk("t4_col", kb_col, 8'hFF);
        send(1'b0, 1'b0, 8'h12);
        tick(2);
        chk("t4_shift_rel", kb_shift, 1'b1);
        chk("t4_ctrl_kept", kb_ctrl, 1'b0);
        send(1'b0, 1'b1, 8'h14);
        tick(2);
        chk("t4_ctrl_rel", kb_ctrl, 1'b1);
        send(1'b0, 1'b0, 8'h11);
        tick(2);
        chk("t4_graph_rel", kb_graph, 1'b1);

        send(1'b1, 1'b0, 8'h5A);
        tick(2);
        send(1'b1, 1'b1, 8'h75);
        kb_row = 8'h7E;
        tick(3);
        chk("t5_col", kb_col, 8'h5F);
        send(1'b1, 1'b0, 8'h75);
        tick(3);
        chk("t5_unmapped", kb_col, 8'h5F);
        kb_row = 8'hFE;
        tick(1);
        chk("t5_row0", kb_col, 8'h7F);
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        tick(2);
        chk("t5_clr_col", kb_col, 8'hFF);
        chk("t5_clr_down", kb_down, 1'b0);

        kb_row = 8'hFD;
        send(1'b1, 1'b0, 8'h1C);
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        tick(3);
        chk("t6_clr_col", kb_col, 8'hFF);
        chk("t6_clr_down", kb_down, 1'b0);

        send(1'b1, 1'b0, 8'h12);
        tick(2);
        send(1'b1, 1'b0, 8'h1C);
        tick(2);
        send(1'b1, 1'b0, 8'h32);
        tick(2);
        chk("t6_retrig", kb_down, 1'b0);
        chk("t6_pre_col", kb_col, 8'hFE);
        chk("t6_pre_shift", kb_shift, 1'b0);
        #2;
        reset_n = 1'b0;
        #1;
        chk("t6_rst_col", kb_col, 8'hFF);
        chk("t6_rst_shift", kb_shift, 1'b1);
        chk("t6_rst_down", kb_down, 1'b0);
        tick(1);
        reset_n = 1'b1;
        tick(2);
        chk("t6_post_col", kb_col, 8'hFF);
        highs = 0;
        for (int i = 0; i < 70; i++) begin
            tick(1);
            if (kb_down) highs++;
        end
        chk("t6_post_down", 8'(highs), 8'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
